// File: rtl/reg_access_master.sv
// Register access initiator: sequences load/check/write/read strobes to the channel.
// Optional REG_ACCESS_SKIP_LOAD_EN caches the last legal register number to skip LOAD/CHECK.
module reg_access_master #(
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cnt_clear,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [31:0]              cmd_reg_num,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_error,
    output logic [31:0]              reg_rx_data,
    output logic                     reg_num_le,
    output logic                     reg_wr_en,
    output logic                     reg_rd_en,
    input  logic [31:0]              reg_tx_data,
    input  logic                     reg_illegal_reg_num,
    output logic [15:0]              txn_count,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ACCESS,
        RDWAIT,
        RESP
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [2:0]  wait_cnt;
    logic        hit;
    logic        cmd_fire;
    logic        rsp_fire;

    assign cmd_ready  = (state == IDLE) && !reset;
    assign rsp_valid  = (state == RESP);
    assign reg_num_le = (state == LOAD);
    assign reg_wr_en  = (state == ACCESS) && wr_q;
    assign reg_rd_en  = (state == ACCESS) && !wr_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;

`ifdef REG_ACCESS_SKIP_LOAD_EN
    logic        cache_vld;
    logic [31:0] cache_num;
    logic [31:0] num_q;

    assign hit = cache_vld && (cmd_reg_num == cache_num);

    // A number that passed CHECK stays loaded in the channel until the next LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_vld <= 1'b0;
            cache_num <= '0;
            num_q     <= '0;
        end else begin
            if (cmd_fire) begin
                num_q <= cmd_reg_num;
            end
            if (state == CHECK) begin
                cache_vld <= !reg_illegal_reg_num;
                cache_num <= num_q;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = hit ? ACCESS : LOAD;
                end
            end
            LOAD:   state_nxt = CHECK;
            CHECK:  state_nxt = reg_illegal_reg_num ? RESP : ACCESS;
            ACCESS: state_nxt = wr_q ? RESP : RDWAIT;
            RDWAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            reg_rx_data <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            txn_count   <= '0;
            err_count   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                wr_q      <= cmd_write;
                wdata_q   <= cmd_wdata;
                rsp_rdata <= '0;
                rsp_error <= 1'b0;
                if (!hit) begin
                    reg_rx_data <= cmd_reg_num;
                end else if (cmd_write) begin
                    reg_rx_data <= cmd_wdata;
                end
            end
            if (state == CHECK) begin
                if (reg_illegal_reg_num) begin
                    rsp_error <= 1'b1;
                end else if (wr_q) begin
                    reg_rx_data <= wdata_q;
                end
            end
            if (state == ACCESS) begin
                wait_cnt <= '0;
            end else if (state == RDWAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (state == RDWAIT && wait_cnt == WAIT_LAST) begin
                rsp_rdata <= reg_tx_data;
            end
            // Clear takes priority over a coincident response
            if (cnt_clear) begin
                txn_count <= '0;
                err_count <= '0;
            end else if (rsp_fire) begin
                txn_count <= txn_count + 16'd1;
                if (rsp_error && err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
// Randomized bench for reg_access_master with a transaction-level timing model.
// Includes a channel register block model (16 legal registers).
module tb_reg_access_master;

    localparam int L  = 2;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cnt_clear = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [31:0]   cmd_reg_num = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic [31:0]   reg_rx_data;
    logic          reg_num_le;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [31:0]   reg_tx_data;
    logic          reg_illegal_reg_num;
    logic [15:0]   txn_count;
    logic [EW-1:0] err_count;

    always #4 clk = ~clk;

    reg_access_master #(.RD_LATENCY(L), .ERR_CNT_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .cnt_clear(cnt_clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_reg_num(cmd_reg_num),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .reg_rx_data(reg_rx_data),
        .reg_num_le(reg_num_le), .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en), .reg_tx_data(reg_tx_data),
        .reg_illegal_reg_num(reg_illegal_reg_num),
        .txn_count(txn_count), .err_count(err_count)
    );

    // Channel: latches number on le, data valid exactly L cycles after rd_en
    logic [31:0] ch_mem [16];
    logic [31:0] ch_num = '0;
    logic [4:1]  rdpipe = '0;
    logic [31:0] junk = 32'hdead_beef;

    assign reg_illegal_reg_num = (ch_num >= 32'd16);
    assign reg_tx_data = rdpipe[L] ? ch_mem[ch_num[3:0]] : junk;

    always @(posedge clk) begin
        rdpipe <= {rdpipe[3:1], reg_rd_en};
        junk   <= $urandom;
        if (reg_num_le) ch_num <= reg_rx_data;
        if (reg_wr_en && ch_num < 32'd16) ch_mem[ch_num[3:0]] <= reg_rx_data;
    end

    // Reference model
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          busy = 1'b0;
    bit          m_w, m_ill, m_hle;
    int          m_a, m_acc, m_rsp;
    logic [31:0] m_num, m_wd, m_rd;
    logic [31:0] m_rx = '0;
    logic [15:0] m_txn = '0;
    int          m_err = 0;
    bit          cval = 1'b0;
    logic [31:0] cnum = '0;
    logic [31:0] mmem [16];

    int n_chk = 0;
    int n_fail = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ch_mem[i] = 32'(i + 6);
            mmem[i]   = 32'(i + 6);
        end
    end

    always @(posedge clk) begin
        bit hitm;
        if (busy && cyc == m_acc && !m_ill && m_w) mmem[m_num[3:0]] = m_wd;
        if (reset) begin
            armed = 1'b1;
            busy  = 1'b0;
            m_rx  = '0;
            m_txn = '0;
            m_err = 0;
            cval  = 1'b0;
        end else begin
            if (busy) begin
                if (m_hle && cyc == m_a + 2) begin
                    if (!m_ill) begin
                        cval = 1'b1;
                        cnum = m_num;
                        if (m_w) m_rx = m_wd;
                    end else begin
                        cval = 1'b0;
                    end
                end
                if (cyc >= m_rsp && rsp_ready) begin
                    busy  = 1'b0;
                    m_txn = m_txn + 16'd1;
                    if (m_ill && m_err < (1 << EW) - 1) m_err++;
                end
            end else if (cmd_valid) begin
                hitm = 1'b0;
`ifdef REG_ACCESS_SKIP_LOAD_EN
                hitm = cval && (cmd_reg_num == cnum);
`endif
                busy  = 1'b1;
                m_a   = cyc;
                m_w   = cmd_write;
                m_num = cmd_reg_num;
                m_wd  = cmd_wdata;
                m_hle = !hitm;
                m_ill = !hitm && (cmd_reg_num >= 32'd16);
                m_acc = hitm ? cyc + 1 : cyc + 3;
                if (m_ill) m_rsp = cyc + 3;
                else if (m_w) m_rsp = m_acc + 1;
                else m_rsp = m_acc + 1 + L;
                m_rd = (m_ill || m_w) ? 32'd0 : mmem[cmd_reg_num[3:0]];
                if (!hitm) m_rx = cmd_reg_num;
                else if (m_w) m_rx = cmd_wdata;
            end
            if (cnt_clear) begin
                m_txn = '0;
                m_err = 0;
            end
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit e_valid;
        if (armed) begin
            e_valid = busy && cyc >= m_rsp;
            chk("cmd_ready", cmd_ready, !reset && !busy);
            chk("reg_num_le", reg_num_le, busy && m_hle && cyc == m_a + 1);
            chk("reg_wr_en", reg_wr_en, busy && !m_ill && m_w && cyc == m_acc);
            chk("reg_rd_en", reg_rd_en, busy && !m_ill && !m_w && cyc == m_acc);
            chk("rsp_valid", rsp_valid, e_valid);
            chk("reg_rx_data", reg_rx_data, m_rx);
            chk("txn_count", txn_count, m_txn);
            chk("err_count", err_count, m_err);
            if (e_valid) begin
                chk("rsp_rdata", rsp_rdata, m_rd);
                chk("rsp_error", rsp_error, m_ill);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic do_cmd(input logic w, input logic [31:0] n, input logic [31:0] d,
                          output int a);
        cmd_write   = w;
        cmd_reg_num = n;
        cmd_wdata   = d;
        cmd_valid   = 1'b1;
        a = -1;
        for (int i = 0; i < 50 && a < 0; i++) begin
            @(negedge clk);
            if (cmd_ready) a = cyc;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (a < 0) begin
            chk("cmd_timeout", 32'd0, 32'd1);
            a = cyc;
        end
    endtask

    initial begin
        int a;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_txn", txn_count, 16'd0);
        chk("rst_rx", reg_rx_data, 32'd0);
        step();

        rsp_ready = 1'b1;
        do_cmd(1'b1, 32'd2, 32'd70000, a);
        goto(a + 1);
        chk("wr_le", reg_num_le, 1'b1);
        chk("wr_le_rx", reg_rx_data, 32'h2);
        goto(a + 3);
        chk("wr_en", reg_wr_en, 1'b1);
        chk("wr_rx", reg_rx_data, 32'h0001_1170);
        goto(a + 4);
        chk("wr_rsp", rsp_valid, 1'b1);
        chk("wr_err", rsp_error, 1'b0);
        goto(a + 5);
        chk("wr_txn", txn_count, 16'd1);
        step();

        rsp_ready = 1'b0;
        do_cmd(1'b0, 32'd8, 32'd0, a);
        goto(a + 3);
        chk("rd_en", reg_rd_en, 1'b1);
        goto(a + 4 + L);
        chk("rd_rsp", rsp_valid, 1'b1);
        chk("rd_data", rsp_rdata, 32'h0000_000e);
        goto(a + 9 + L);
        chk("hold_rsp", rsp_valid, 1'b1);
        chk("hold_data", rsp_rdata, 32'h0000_000e);
        chk("hold_ready", cmd_ready, 1'b0);
        step();
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("post_rsp_ready", cmd_ready, 1'b1);
        step();

        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        do_cmd(1'b0, 32'h20, 32'd0, a);
        goto(a + 3);
        chk("ill_rsp", rsp_valid, 1'b1);
        chk("ill_err", rsp_error, 1'b1);
        chk("ill_data", rsp_rdata, 32'd0);
        goto(a + 4);
        chk("ill_cnt", err_count, 2'd1);
        step();
        repeat (4) do_cmd(1'b1, 32'h21, 32'd5, a);
        goto(a + 4);
        chk("err_sat", err_count, 2'd3);
        step();

        do_cmd(1'b1, 32'd3, 32'h1234, a);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr", reg_wr_en, 1'b0);
        chk("rst_mid_rsp", rsp_valid, 1'b0);
        chk("rst_mid_txn", txn_count, 16'd0);
        step();
        do_cmd(1'b0, 32'd3, 32'd0, a);
        goto(a + 1);
        chk("restart_le", reg_num_le, 1'b1);
        step();

`ifdef REG_ACCESS_SKIP_LOAD_EN
        do_cmd(1'b0, 32'd5, 32'd0, a);
        goto(a + 1);
        chk("skip_first_le", reg_num_le, 1'b1);
        step();
        do_cmd(1'b0, 32'd5, 32'd0, a);
        goto(a + 1);
        chk("skip_no_le", reg_num_le, 1'b0);
        chk("skip_rd", reg_rd_en, 1'b1);
        step();
        do_cmd(1'b0, 32'd6, 32'd0, a);
        goto(a + 1);
        chk("skip_new_le", reg_num_le, 1'b1);
        step();
`endif

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(299) == 0);
            cnt_clear   = ($urandom_range(39) == 0);
            cmd_valid   = ($urandom_range(2) != 0);
            cmd_write   = $urandom_range(1) == 1;
            cmd_reg_num = 32'($urandom_range(19));
            cmd_wdata   = $urandom;
            rsp_ready   = ($urandom_range(2) != 0);
            step();
        end
        reset = 1'b0;
        cmd_valid = 1'b0;
        step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
